cla_acc_pipe: RTL and testbench
===============================

# cla_acc_pipe

Parametrised, clocked carry-lookahead adder/accumulator: the registered successor to the 4-bit CLA. It generalises the datapath to WIDTH bits built from 4-bit lookahead slices, and adds subtract, accumulate and load modes. It is a two-register pipeline with valid/ready handshakes on both sides, for use as the arithmetic unit behind sequencers that stream operand pairs.

## Interface
- WIDTH, 32: datapath width; multiple of 4, range 4..64.
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  operand/op presented.
- in_ready  output  1  block accepts the transfer this cycle.
- op  input  2  00 ADD, 01 SUB, 10 ACC, 11 LOAD.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B; ignored in ACC/LOAD.
- ci  input  1  carry-in; used by ADD only.
- out_valid  output  1  result holds valid data.
- out_ready  input  1  consumer takes the result.
- s  output  WIDTH  sum/difference/accumulator result.
- co  output  1  carry-out (SUB: 1 = no borrow).
- ovf  output  1  two's-complement overflow.
- zero  output  1  s == 0.

## Operation
- Stage A is the input register {op, a, b, ci, a_valid}. It loads on in_valid && in_ready.
- Stage B is the output register {s, co, ovf, zero, out_valid}. It loads from the CLA combinational result of stage A when stage A advances.
- Internal accumulator acc[WIDTH-1:0] is architectural state.
- Operations, computed when stage A advances:
  - ADD: s = a + b + ci.
  - SUB: s = a + ~b + 1. ci ignored.
  - ACC: s = acc + a. acc <= s.
  - LOAD: s = a, co = 0, ovf = 0. acc <= a.
  - ADD and SUB do not modify acc.
- Width rules: a WIDTH+1-bit result is split into {co, s}. ovf = (x[MSB] == y'[MSB]) && (s[MSB] != x[MSB]), where x, y' are the adder inputs after inversion.
- Carry chain: WIDTH/4 lookahead slices rippling group carry. Each slice computes generate/propagate internally.
- Wrap-around: ACC overflow wraps modulo 2^WIDTH. It flags co/ovf but never saturates.
- Back-to-back ACC: acc updates at the same edge the op leaves stage A, so the next ACC sees the updated value. No bubble, no forwarding hazard.

## Timing
- Reset (async assert, sync release): a_valid=0, out_valid=0, s=0, co=0, ovf=0, zero=0, acc=0. in_ready=1 immediately after reset.
- Handshake rules:
  - a_adv = a_valid && (!out_valid || out_ready).
  - in_ready = !a_valid || a_adv. This is a combinational path from out_ready.
- Latency: an operand accepted at edge k appears with out_valid=1 after edge k+1.
- Throughput is 1 op/cycle while out_ready=1.
- Stall: out_valid && !out_ready holds s/co/ovf/zero stable. Stage A then fills and holds, and in_ready drops. Nothing is lost or duplicated.
- Release: out_ready=1 with stage A full moves A into B and accepts new input on the same edge.
- out_valid falls only on out_ready with stage A empty.
- in_valid && !in_ready: the input is ignored. The source must hold it.
- Reset mid-operation: in-flight ops are discarded and acc is cleared. There is no partial-update state.

## Structure
- Shared package: op encodings OP_ADD/OP_SUB/OP_ACC/OP_LOAD, and the WIDTH legality check (multiple of 4).
- Sub-module: the existing cla4 (s, co, a, b, ci), instantiated WIDTH/4 times via generate with the carry chained.
- Top: the two stage registers, acc, handshake logic, mode muxing, flags.

## Test plan
All cases use WIDTH=16.
- Reset: pulse reset_n low mid-stream. All outputs are 0 and in_ready=1 during reset; the first op after release has the normal 1-edge latency.
- ADD: 0x7FFF+0x0001, ci=0 -> s=0x8000, co=0, ovf=1. 0xFFFF+0x0000, ci=1 -> s=0x0000, co=1, zero=1.
- SUB: 0x0005-0x0007 -> s=0xFFFE, co=0, ovf=0. 0x8000-0x0001 -> s=0x7FFF, co=1, ovf=1.
- LOAD/ACC:
  - LOAD 0xFFF0 -> s=0xFFF0.
  - Back-to-back ACC 0x0008, ACC 0x0008 -> s=0xFFF8, then s=0x0000 with co=1, zero=1.
  - An interleaved ADD leaves acc unchanged.
- Backpressure: stream 4 ADDs with out_ready low for 3 cycles. in_ready drops after 2 accepts, results come out in order with none lost or duplicated, and s stays stable while stalled.
- Random: 1000 random ops with random in_valid/out_ready, checked against a scoreboard model including acc.

Source files
------------

// File: rtl/cla_acc_pipe_pkg.sv
// cla_acc_pipe shared definitions: op encodings, slice width and the
// datapath-width legality check used by the top at elaboration.
package cla_acc_pipe_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    localparam int unsigned SLICE_W = 4;

    // Datapath must tile exactly into 4-bit lookahead slices.
    function automatic bit width_ok(input int unsigned w);
        return (w % SLICE_W == 0) && (w >= 4) && (w <= 64);
    endfunction

endpackage

// File: rtl/cla_acc_pipe_if.sv
// cla_acc_pipe handshake bundle: input side (in_valid/in_ready, op, a, b,
// ci) and output side (out_valid/out_ready, s, co, ovf, zero).
interface cla_acc_pipe_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             ci;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] s;
    logic             co;
    logic             ovf;
    logic             zero;

    // Sequencer side: produces operands, consumes results.
    modport master (
        output in_valid, op, a, b, ci, out_ready,
        input  in_ready, out_valid, s, co, ovf, zero
    );

    // Arithmetic unit side.
    modport slave (
        input  in_valid, op, a, b, ci, out_ready,
        output in_ready, out_valid, s, co, ovf, zero
    );
endinterface

// File: rtl/cla_acc_pipe_cla4.sv
// cla4: 4-bit carry-lookahead slice; generate/propagate computed locally.
// Ports: s[3:0] sum, co carry-out, a/b[3:0] addends, ci carry-in.
module cla4 (
    output logic [3:0] s,
    output logic       co,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       ci
);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:1] c;

    always_comb begin
        g = a & b;
        p = a ^ b;

        c[1] = g[0] | (p[0] & ci);

        c[2] = g[1]
             | (p[1] & g[0])
             | (p[1] & p[0] & ci);

        c[3] = g[2]
             | (p[2] & g[1])
             | (p[2] & p[1] & g[0])
             | (p[2] & p[1] & p[0] & ci);

        c[4] = g[3]
             | (p[3] & g[2])
             | (p[3] & p[2] & g[1])
             | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & ci);

        s  = p ^ {c[3:1], ci};
        co = c[4];
    end
endmodule

// File: rtl/cla_acc_pipe.sv
// cla_acc_pipe: two-register CLA add/sub/accumulate/load pipeline.
// Ports: clk, reset_n (async low), bus (slave side of cla_acc_pipe_if).
module cla_acc_pipe
    import cla_acc_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic           clk,
    input  logic           reset_n,
    cla_acc_pipe_if.slave  bus
);
    localparam int unsigned NS  = WIDTH / SLICE_W;
    localparam int unsigned MSB = WIDTH - 1;

    if (!width_ok(WIDTH)) begin : g_bad_width
        $error("cla_acc_pipe: WIDTH must be a multiple of 4 in 4..64");
    end

    // Stage A: captured operands.
    logic             a_valid_q, a_valid_d;
    op_e              op_q, op_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic             ci_q, ci_d;

    // Stage B: registered result.
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic             co_q, co_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    // Architectural accumulator.
    logic [WIDTH-1:0] acc_q, acc_d;

    logic             a_adv;
    logic             in_ready;
    logic             in_fire;

    // Adder inputs after mode muxing / inversion.
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic [NS:0]      c;

    logic [WIDTH-1:0] res_s;
    logic             res_co;
    logic             res_ovf;
    logic             is_load;
    logic             wr_acc;

    // Stage A drains whenever B is empty or being consumed this cycle,
    // so in_ready is combinational from out_ready.
    always_comb begin
        a_adv    = a_valid_q && (!out_valid_q || bus.out_ready);
        in_ready = !a_valid_q || a_adv;
        in_fire  = bus.in_valid && in_ready;
    end

    always_comb begin
        x   = opa_q;
        y   = opb_q;
        cin = ci_q;
        unique case (op_q)
            OP_ADD: begin
                x   = opa_q;
                y   = opb_q;
                cin = ci_q;
            end
            OP_SUB: begin
                x   = opa_q;
                y   = ~opb_q;
                cin = 1'b1;
            end
            OP_ACC: begin
                x   = acc_q;
                y   = opa_q;
                cin = 1'b0;
            end
            OP_LOAD: begin
                x   = opa_q;
                y   = '0;
                cin = 1'b0;
            end
        endcase
    end

    assign c[0] = cin;

    for (genvar i = 0; i < NS; i++) begin : g_slice
        cla4 u_cla4 (
            .s  (sum[SLICE_W*i +: SLICE_W]),
            .co (c[i+1]),
            .a  (x[SLICE_W*i +: SLICE_W]),
            .b  (y[SLICE_W*i +: SLICE_W]),
            .ci (c[i])
        );
    end

    always_comb begin
        is_load = (op_q == OP_LOAD);
        wr_acc  = (op_q == OP_ACC) || is_load;
        res_s   = sum;
        res_co  = is_load ? 1'b0 : c[NS];
        // Overflow: like-signed adder inputs producing an opposite sign.
        res_ovf = is_load ? 1'b0
                : (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB]);
    end

    always_comb begin
        a_valid_d   = a_valid_q;
        op_d        = op_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        ci_d        = ci_q;
        out_valid_d = out_valid_q;
        s_d         = s_q;
        co_d        = co_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        acc_d       = acc_q;

        if (in_fire) begin
            a_valid_d = 1'b1;
            op_d      = op_e'(bus.op);
            opa_d     = bus.a;
            opb_d     = bus.b;
            ci_d      = bus.ci;
        end else if (a_adv) begin
            a_valid_d = 1'b0;
        end

        // acc moves on the same edge the op leaves A, so a following
        // ACC already in A sees the new value next cycle.
        if (a_adv) begin
            out_valid_d = 1'b1;
            s_d         = res_s;
            co_d        = res_co;
            ovf_d       = res_ovf;
            zero_d      = (res_s == '0);
            if (wr_acc) begin
                acc_d = res_s;
            end
        end else if (bus.out_ready) begin
            // Not advancing with out_ready high implies A is empty.
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_valid_q   <= 1'b0;
            op_q        <= OP_ADD;
            opa_q       <= '0;
            opb_q       <= '0;
            ci_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s_q         <= '0;
            co_q        <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
            acc_q       <= '0;
        end else begin
            a_valid_q   <= a_valid_d;
            op_q        <= op_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            ci_q        <= ci_d;
            out_valid_q <= out_valid_d;
            s_q         <= s_d;
            co_q        <= co_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
            acc_q       <= acc_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.s         = s_q;
    assign bus.co        = co_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_cla_acc_pipe.sv
// Bench for cla_acc_pipe at WIDTH=16: directed cases plus a random
// stream, all results compared in order against an expectation queue.
module tb_cla_acc_pipe;
    import cla_acc_pipe_pkg::*;

    localparam int W = 16;

    typedef struct packed {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        logic         zero;
    } res_t;

    logic clk = 1'b0;
    logic reset_n;

    always #5 clk = ~clk;

    cla_acc_pipe_if #(.WIDTH(W)) bus ();

    cla_acc_pipe #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    res_t         q[$];
    res_t         dir_exp;
    bit           dir_en;
    logic [W-1:0] m_acc;
    int           checks   = 0;
    int           failures = 0;
    bit           accepted;
    bit           taken;

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic res_t mk(input logic [W-1:0] s, input logic co,
                                input logic ovf, input logic zero);
        res_t r;
        r.s    = s;
        r.co   = co;
        r.ovf  = ovf;
        r.zero = zero;
        return r;
    endfunction

    // Reference arithmetic; also tracks the accumulator in accept order.
    function automatic res_t model(input logic [1:0] op,
                                   input logic [W-1:0] a,
                                   input logic [W-1:0] b,
                                   input logic ci);
        logic [W:0]   t;
        logic [W-1:0] x;
        logic [W-1:0] y;
        res_t         r;
        case (op)
            2'b00: begin
                x = a; y = b;
                t = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
            end
            2'b01: begin
                x = a; y = ~b;
                t = {1'b0, a} + {1'b0, ~b} + 17'd1;
            end
            2'b10: begin
                x = m_acc; y = a;
                t = {1'b0, m_acc} + {1'b0, a};
            end
            default: begin
                x = a; y = '0;
                t = {1'b0, a};
            end
        endcase
        r.s    = t[W-1:0];
        r.co   = (op == 2'b11) ? 1'b0 : t[W];
        r.ovf  = (op == 2'b11) ? 1'b0
               : (x[W-1] == y[W-1]) && (r.s[W-1] != x[W-1]);
        r.zero = (r.s == '0);
        if (op[1]) m_acc = r.s;
        return r;
    endfunction

    // One cycle: sample just after the falling edge, then cross the
    // rising edge and return at the next falling edge.
    task automatic tick();
        res_t e;
        #1;
        accepted = bus.in_valid && bus.in_ready;
        taken    = bus.out_valid && bus.out_ready;
        if (taken) begin
            checks++;
            assert (q.size() != 0) else begin
                failures++;
                $error("FAIL spurious_out observed=s %h expected=no output",
                       bus.s);
            end
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("s", bus.s, e.s);
                chk("co", bus.co, e.co);
                chk("ovf", bus.ovf, e.ovf);
                chk("zero", bus.zero, e.zero);
            end
        end
        if (accepted) begin
            e = model(bus.op, bus.a, bus.b, bus.ci);
            if (dir_en) e = dir_exp;
            q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic ci,
                        input res_t exp);
        int n = 0;
        dir_en       = 1'b1;
        dir_exp      = exp;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        bus.ci       = ci;
        do begin
            tick();
            n++;
        end while (!accepted && n < 20);
        checks++;
        assert (accepted) else begin
            failures++;
            $error("FAIL send_timeout observed=not accepted expected=accept");
        end
        bus.in_valid = 1'b0;
        dir_en       = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        chk("drain_left", q.size(), 0);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_out_valid"}, bus.out_valid, 0);
        chk({tag, "_s"}, bus.s, 0);
        chk({tag, "_co"}, bus.co, 0);
        chk({tag, "_ovf"}, bus.ovf, 0);
        chk({tag, "_zero"}, bus.zero, 0);
        chk({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        int           idx;
        int           cyc;
        int           n_sent;
        logic [W-1:0] ra;
        logic [W-1:0] rb;

        reset_n       = 1'b0;
        dir_en        = 1'b0;
        m_acc         = '0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'b00;
        bus.a         = '0;
        bus.b         = '0;
        bus.ci        = 1'b0;
        bus.out_ready = 1'b1;

        @(negedge clk);
        #1;
        chk_idle("rst");
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk_idle("post_rst");
        @(negedge clk);

        // ADD
        send(2'b00, 16'h7FFF, 16'h0001, 1'b0, mk(16'h8000, 0, 1, 0));
        send(2'b00, 16'hFFFF, 16'h0000, 1'b1, mk(16'h0000, 1, 0, 1));
        // SUB (ci must be ignored)
        send(2'b01, 16'h0005, 16'h0007, 1'b1, mk(16'hFFFE, 0, 0, 0));
        send(2'b01, 16'h8000, 16'h0001, 1'b0, mk(16'h7FFF, 1, 1, 0));
        // LOAD then back-to-back ACC (b ignored)
        send(2'b11, 16'hFFF0, 16'h1234, 1'b1, mk(16'hFFF0, 0, 0, 0));
        send(2'b10, 16'h0008, 16'hFFFF, 1'b1, mk(16'hFFF8, 0, 0, 0));
        send(2'b10, 16'h0008, 16'hFFFF, 1'b0, mk(16'h0000, 1, 0, 1));
        // Interleaved ADD must leave acc alone
        send(2'b11, 16'h0010, 16'h0000, 1'b0, mk(16'h0010, 0, 0, 0));
        send(2'b00, 16'h1234, 16'h0001, 1'b0, mk(16'h1235, 0, 0, 0));
        send(2'b10, 16'h0001, 16'h0000, 1'b0, mk(16'h0011, 0, 0, 0));
        drain();

        // Backpressure: out_ready low for cycles 0..4
        idx = 0;
        cyc = 0;
        while (idx < 4 && cyc < 40) begin
            bus.in_valid  = 1'b1;
            bus.op        = 2'b00;
            bus.a         = W'(idx + 1);
            bus.b         = W'(idx + 1);
            bus.ci        = 1'b0;
            bus.out_ready = (cyc >= 5);
            if (cyc >= 2 && cyc <= 4) begin
                #1;
                chk("bp_in_ready", bus.in_ready, 0);
                chk("bp_accepts", idx, 2);
                chk("bp_out_valid", bus.out_valid, 1);
                chk("bp_stall_s", bus.s, 16'h0002);
            end
            tick();
            if (accepted) idx++;
            cyc++;
        end
        chk("bp_sent", idx, 4);
        bus.in_valid = 1'b0;
        drain();

        // Reset in the middle of a stalled stream
        bus.out_ready = 1'b0;
        send(2'b11, 16'h1111, 16'h0000, 1'b0, mk(16'h1111, 0, 0, 0));
        send(2'b00, 16'h0001, 16'h0001, 1'b0, mk(16'h0002, 0, 0, 0));
        #2;
        reset_n = 1'b0;
        #1;
        chk_idle("mid_rst");
        q.delete();
        m_acc = '0;
        @(negedge clk);
        reset_n       = 1'b1;
        bus.out_ready = 1'b1;
        send(2'b10, 16'h0005, 16'h0000, 1'b0, mk(16'h0005, 0, 0, 0));
        #1;
        chk("lat_edge_k", bus.out_valid, 0);
        tick();
        #1;
        chk("lat_edge_k1", bus.out_valid, 1);
        drain();

        // Random stream with random handshakes
        n_sent = 0;
        cyc    = 0;
        while ((n_sent < 1000 || q.size() != 0) && cyc < 20000) begin
            if (!bus.in_valid && n_sent < 1000
                && $urandom_range(0, 9) < 7) begin
                case ($urandom_range(0, 4))
                    0:       ra = 16'hFFFF;
                    1:       ra = 16'h8000;
                    2:       ra = 16'h0000;
                    default: ra = W'($urandom);
                endcase
                rb           = ($urandom_range(0, 4) == 0) ? 16'h7FFF
                                                           : W'($urandom);
                bus.in_valid = 1'b1;
                bus.op       = 2'($urandom_range(0, 3));
                bus.a        = ra;
                bus.b        = rb;
                bus.ci       = 1'($urandom_range(0, 1));
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
            tick();
            if (accepted) begin
                n_sent++;
                bus.in_valid = 1'b0;
            end
            cyc++;
        end
        chk("rand_sent", n_sent, 1000);
        chk("rand_left", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
